ex_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage. It consumes the forwarded ALU operands and the funct3 field that the ID/EX pipeline register delivers. It stalls the front of the pipeline while it iterates, and presents a 32-bit result for the EX/MEM register to capture. One operation is in flight at a time.

---
 rtl/ex_muldiv_unit_if.sv | 26 ++
 rtl/ex_muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage handshake between the pipeline and the iterative mul/div unit.
// Pipeline side (master) drives the operation; the unit (slave) returns stall/valid/result.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            ex_start;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_op_a;
  logic [XLEN-1:0] ex_op_b;
  logic            pipe_advance;
  logic            flush;
  logic            md_stall;
  logic            md_busy;
  logic            md_valid;
  logic [XLEN-1:0] md_result;

  modport master (
    output ex_start, ex_funct3, ex_op_a, ex_op_b, pipe_advance, flush,
    input  md_stall, md_busy, md_valid, md_result
  );

  modport slave (
    input  ex_start, ex_funct3, ex_op_a, ex_op_b, pipe_advance, flush,
    output md_stall, md_busy, md_valid, md_result
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M mul/div: 33-cycle ops (1 cycle for div-by-zero/overflow), result held in DONE
// until pipe_advance or flush; md_stall holds the front of the pipe while the result is pending.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  ex_muldiv_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            sign_q, sign_d;

  // Incoming-operation decode
  logic            start, is_div, b_zero, ovf;
  logic            sgn_a, sgn_b, s_a, s_b;
  logic [XLEN-1:0] mag_a, mag_b, fast_res;

  always_comb begin
    start  = bus.ex_start & ~bus.flush;
    is_div = bus.ex_funct3[2];
    sgn_a  = (bus.ex_funct3 == 3'b001) || (bus.ex_funct3 == 3'b010) ||
             (bus.ex_funct3 == 3'b100) || (bus.ex_funct3 == 3'b110);
    sgn_b  = (bus.ex_funct3 == 3'b001) || (bus.ex_funct3 == 3'b100) ||
             (bus.ex_funct3 == 3'b110);
    s_a    = sgn_a & bus.ex_op_a[XLEN-1];
    s_b    = sgn_b & bus.ex_op_b[XLEN-1];
    mag_a  = s_a ? -bus.ex_op_a : bus.ex_op_a;
    mag_b  = s_b ? -bus.ex_op_b : bus.ex_op_b;
    b_zero = (bus.ex_op_b == '0);
    ovf    = ((bus.ex_funct3 == 3'b100) || (bus.ex_funct3 == 3'b110)) &&
             (bus.ex_op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.ex_op_b);
    // Division by zero and signed overflow resolve without iterating
    if (b_zero) fast_res = bus.ex_funct3[1] ? bus.ex_op_a : '1;
    else        fast_res = bus.ex_funct3[1] ? '0 : bus.ex_op_a;
  end

  // One iteration step; hi/lo hold product or remainder/quotient
  logic [XLEN:0]     mul_sum, div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub, it_hi, it_lo, quo_s, rem_s, fin;
  logic [2*XLEN-1:0] prod_s;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_sh  = {hi_q, lo_q[XLEN-1]};
    div_ge  = (div_sh >= {1'b0, a_q});
    div_sub = div_sh[XLEN-1:0] - a_q;
    if (f3_q[2]) begin
      it_hi = div_ge ? div_sub : div_sh[XLEN-1:0];
      it_lo = {lo_q[XLEN-2:0], div_ge};
    end else begin
      it_hi = mul_sum[XLEN:1];
      it_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod_s = sign_q ? -{it_hi, it_lo} : {it_hi, it_lo};
    quo_s  = sign_q ? -it_lo : it_lo;
    rem_s  = sign_q ? -it_hi : it_hi;
    case (f3_q)
      3'b000:                 fin = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin = quo_s;
      default:                fin = rem_s;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      f3_q    <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
    end
  end

  // Next state and datapath
  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d   = bus.ex_funct3;
          cnt_d  = '0;
          hi_d   = '0;
          // Remainder takes the dividend's sign; product and quotient take sA^sB
          sign_d = (bus.ex_funct3[2] & bus.ex_funct3[1]) ? s_a : (s_a ^ s_b);
          a_d    = is_div ? mag_b : mag_a;
          lo_d   = is_div ? mag_a : mag_b;
          if (is_div && (b_zero || ovf)) begin
            res_d   = fast_res;
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        hi_d  = it_hi;
        lo_d  = it_lo;
        cnt_d = cnt_q + 5'd1;
        if ((cnt_q == 5'd31) && !bus.flush) begin
          res_d   = fin;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.pipe_advance) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
  end

  // Outputs
  always_comb begin
    bus.md_busy   = (state_q == S_BUSY);
    bus.md_valid  = (state_q == S_DONE);
    bus.md_result = res_q;
    bus.md_stall  = ~rst & bus.ex_start & ~bus.flush &
                    ((state_q == S_IDLE) || (state_q == S_BUSY));
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vector table, corner sequences,
// and randomized ops checked against a plain-arithmetic RV32M model.
module tb_ex_muldiv_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  ex_muldiv_unit_if #(.XLEN(32)) bus ();

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          stall;
    int          busy;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = ia / ib; return q;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = ia % ib; return q;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Drives one op at a negedge, counts stall/busy cycles, checks the result,
  // optionally holds DONE for `hold` cycles, then retires it via pipe_advance.
  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int es, input int eb, input int hold);
    int sc, bc, n;
    sc = 0; bc = 0; n = 0;
    bus.ex_funct3 = f3;
    bus.ex_op_a   = a;
    bus.ex_op_b   = b;
    bus.ex_start  = 1'b1;
    while (!bus.md_valid && n < 40) begin
      #1;
      if (bus.md_stall) sc++;
      if (bus.md_busy)  bc++;
      @(negedge clk);
      n++;
    end
    #1;
    chk({nm, "_valid"}, {31'd0, bus.md_valid}, 32'd1);
    chk({nm, "_result"}, bus.md_result, exp);
    chk({nm, "_stall_cycles"}, sc, es);
    chk({nm, "_busy_cycles"}, bc, eb);
    chk({nm, "_stall_in_done"}, {31'd0, bus.md_stall}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      chk({nm, "_hold_valid"}, {31'd0, bus.md_valid}, 32'd1);
      chk({nm, "_hold_result"}, bus.md_result, exp);
      chk({nm, "_hold_stall"}, {31'd0, bus.md_stall}, 32'd0);
      chk({nm, "_hold_busy"}, {31'd0, bus.md_busy}, 32'd0);
    end
    bus.pipe_advance = 1'b1;
    @(negedge clk);
    bus.pipe_advance = 1'b0;
    bus.ex_start     = 1'b0;
    #1;
    chk({nm, "_exit_valid"}, {31'd0, bus.md_valid}, 32'd0);
    @(negedge clk);
  endtask

  vec_t vt[12];

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    int          r, vcnt;
    logic        fast;

    n_cmp = 0;
    n_bad = 0;
    vt[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 32};
    vt[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, 32};
    vt[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 32};
    vt[3]  = '{3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33, 32};
    vt[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 32};
    vt[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 32};
    vt[6]  = '{3'b101, 32'd100,        32'd7,         32'd14,        33, 32};
    vt[7]  = '{3'b111, 32'd100,        32'd7,         32'd2,         33, 32};
    vt[8]  = '{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  0};
    vt[9]  = '{3'b111, 32'd5,          32'd0,         32'd5,         1,  0};
    vt[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0};
    vt[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  0};

    bus.ex_start     = 1'b1;
    bus.ex_funct3    = 3'b000;
    bus.ex_op_a      = 32'd3;
    bus.ex_op_b      = 32'd4;
    bus.pipe_advance = 1'b0;
    bus.flush        = 1'b0;
    rst              = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_stall", {31'd0, bus.md_stall}, 32'd0);
    chk("reset_busy",  {31'd0, bus.md_busy},  32'd0);
    chk("reset_valid", {31'd0, bus.md_valid}, 32'd0);
    chk("reset_result", bus.md_result, 32'd0);
    bus.ex_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vt[i].f3, vt[i].a, vt[i].b, vt[i].exp,
             vt[i].stall, vt[i].busy, 0);

    // DONE held with ex_start still high: no restart, stable result
    run_op("done_hold", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 32, 3);

    // flush beats ex_start in IDLE
    bus.ex_funct3 = 3'b101; bus.ex_op_a = 32'd9; bus.ex_op_b = 32'd0;
    bus.ex_start = 1'b1; bus.flush = 1'b1;
    #1;
    chk("flush_idle_stall", {31'd0, bus.md_stall}, 32'd0);
    @(negedge clk);
    bus.ex_start = 1'b0; bus.flush = 1'b0;
    #1;
    chk("flush_idle_valid", {31'd0, bus.md_valid}, 32'd0);
    chk("flush_idle_busy",  {31'd0, bus.md_busy},  32'd0);
    @(negedge clk);

    // flush mid-BUSY
    bus.ex_funct3 = 3'b000; bus.ex_op_a = 32'd11; bus.ex_op_b = 32'd13;
    bus.ex_start = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("pre_flush_busy", {31'd0, bus.md_busy}, 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.ex_start = 1'b0;
    #1;
    chk("flush_busy_busy",  {31'd0, bus.md_busy},  32'd0);
    chk("flush_busy_valid", {31'd0, bus.md_valid}, 32'd0);
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (bus.md_valid) vcnt++;
    end
    chk("flush_no_valid", vcnt, 32'd0);
    @(negedge clk);
    run_op("after_flush", 3'b101, 32'd100, 32'd7, 32'd14, 33, 32, 0);

    // async reset mid-BUSY
    bus.ex_funct3 = 3'b011; bus.ex_op_a = 32'hDEAD_BEEF; bus.ex_op_b = 32'h1234_5678;
    bus.ex_start = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_stall",  {31'd0, bus.md_stall}, 32'd0);
    chk("arst_busy",   {31'd0, bus.md_busy},  32'd0);
    chk("arst_valid",  {31'd0, bus.md_valid}, 32'd0);
    chk("arst_result", bus.md_result, 32'd0);
    @(negedge clk);
    rst = 1'b0; bus.ex_start = 1'b0;
    @(negedge clk);
    run_op("after_arst", 3'b011, 32'hDEAD_BEEF, 32'h1234_5678,
           model(3'b011, 32'hDEAD_BEEF, 32'h1234_5678), 33, 32, 0);

    // randomized ops against the reference model
    for (int k = 0; k < 24; k++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      r   = $urandom_range(0, 7);
      if (r == 0) rb = 32'd0;
      else if (r == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (r == 2) rb = 32'($urandom_range(1, 15));
      fast = rf3[2] && ((rb == 32'd0) ||
             (!rf3[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF));
      run_op($sformatf("rnd%0d_f%0d", k, rf3), rf3, ra, rb, model(rf3, ra, rb),
             fast ? 1 : 33, fast ? 0 : 32, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
